// File: rtl/vec_sig_harness_pkg.sv
// Shared types and helpers for the stimulus/signature harness.
// The helpers take full MAX_W-wide operands so a single definition serves
// every register width; callers zero-extend in and cast the result back down.
package harness_pkg;

   localparam int MAX_W = 1024;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   // Galois right-shift step. Zero-extended operands keep the upper bits at
   // zero, so the low W bits of the result are the W-bit step.
   function automatic logic [MAX_W-1:0] galois_step(input logic [MAX_W-1:0] s,
                                                    input logic [MAX_W-1:0] poly);
      return (s >> 1) ^ (s[0] ? poly : '0);
   endfunction

   // XOR of all sig_w-bit slices, LSB aligned. Zero-extension of the data
   // provides the padding of the last partial slice.
   function automatic logic [MAX_W-1:0] fold(input logic [MAX_W-1:0] data,
                                             input int sig_w);
      logic [MAX_W-1:0] acc;
      logic [MAX_W-1:0] mask;
      acc  = '0;
      mask = {MAX_W{1'b1}} >> (MAX_W - sig_w);
      for (int b = 0; b < MAX_W; b += sig_w) begin
         acc = acc ^ ((data >> b) & mask);
      end
      return acc;
   endfunction

endpackage

// File: rtl/vec_sig_harness_if.sv
// Bus between the bench and the harness: run control, DUT vector and
// response, status and signature. The harness takes the slave side.
interface vec_sig_harness_if #(
   parameter int IN_W    = 64,
   parameter int OUT_W   = 474,
   parameter int SIG_W   = 32,
   parameter int NUM_VEC = 21
);
   localparam int VW = $clog2(NUM_VEC + 1);

   logic             start;
   logic             abort;
   logic [IN_W-1:0]  seed;
   logic [IN_W-1:0]  dut_in;
   logic [OUT_W-1:0] dut_out;
   logic             busy;
   logic             done;
   logic [VW-1:0]    vec_idx;
   logic [SIG_W-1:0] signature;

   modport master (
      output start, abort, seed, dut_out,
      input  dut_in, busy, done, vec_idx, signature
   );

   modport slave (
      input  start, abort, seed, dut_out,
      output dut_in, busy, done, vec_idx, signature
   );

endinterface

// File: rtl/vec_sig_harness_galois_reg.sv
// Galois shift register with an injection input: with inject tied to zero
// it is a plain LFSR, with inject driven it behaves as a MISR.
module galois_reg
   import harness_pkg::*;
#(
   parameter int            W    = 8,
   parameter logic [W-1:0]  POLY = '1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] inject,
   output logic [W-1:0] q
);

   // Clear has priority over load, load over a step; otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clear) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (step) begin
         q <= W'(galois_step(MAX_W'(q), MAX_W'(POLY))) ^ inject;
      end
   end

endmodule

// File: rtl/vec_sig_harness.sv
// Stimulus/signature harness: drives a run of pseudo-random vectors into a
// DUT and compacts the responses into a MISR signature.
module vec_sig_harness
   import harness_pkg::*;
#(
   parameter int               IN_W       = 64,
   parameter int               OUT_W      = 474,
   parameter int               SIG_W      = 32,
   parameter int               NUM_VEC    = 21,
   parameter int               LAT        = 0,
   parameter logic [IN_W-1:0]  POLY       = IN_W'(64'hD800000000000000),
   parameter logic [SIG_W-1:0] SIG_POLY   = SIG_W'(32'h82608EDB),
   parameter bit               ZERO_FIRST = 1'b1
) (
   input logic              clk,
   input logic              rst,
   vec_sig_harness_if.slave bus
);

   localparam int VW = $clog2(NUM_VEC + 1);
   localparam int PW = (LAT > 0) ? LAT : 1;
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [VW-1:0] LAST_IDX   = VW'(NUM_VEC - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'((LAT > 0) ? LAT - 1 : 0);

   state_t           state;
   state_t           state_nxt;
   logic [IN_W-1:0]  dut_in_q;
   logic [IN_W-1:0]  seed_nz;
   logic [IN_W-1:0]  lfsr_q;
   logic [IN_W-1:0]  lfsr_load;
   logic [VW-1:0]    idx_q;
   logic [CW-1:0]    drain_q;
   logic [PW-1:0]    valid_pipe;
   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] folded;
   logic             accept;
   logic             advance;
   logic             valid_now;
   logic             capture;

   assign seed_nz   = (bus.seed == '0) ? IN_W'(1) : bus.seed;
   assign accept    = bus.start && !bus.abort && (state == IDLE || state == DONE);
   assign advance   = (state == RUN) && (idx_q != LAST_IDX) && !bus.abort;
   assign valid_now = (state == RUN);
   assign capture   = ((LAT == 0) ? valid_now : valid_pipe[PW-1]) && !bus.abort;
   assign folded    = SIG_W'(fold(MAX_W'(bus.dut_out), SIG_W));

   // The LFSR always runs one vector ahead of dut_in, so with a non-zero
   // first vector it is preloaded with the seed already stepped once.
   assign lfsr_load = ZERO_FIRST ? seed_nz
                                 : IN_W'(galois_step(MAX_W'(seed_nz), MAX_W'(POLY)));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides everything, including start.
   always_comb begin
      state_nxt = state;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (bus.start) state_nxt = RUN;
            RUN:        if (idx_q == LAST_IDX) state_nxt = (LAT > 0) ? DRAIN : DONE;
            DRAIN:      if (drain_q == LAST_DRAIN) state_nxt = DONE;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   // Vector register, index, drain counter and the valid pipe that tags
   // each applied vector until its response reaches dut_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dut_in_q   <= '0;
         idx_q      <= '0;
         drain_q    <= '0;
         valid_pipe <= '0;
      end else if (bus.abort) begin
         dut_in_q   <= '0;
         idx_q      <= '0;
         drain_q    <= '0;
         valid_pipe <= '0;
      end else begin
         valid_pipe <= (valid_pipe << 1) | PW'(valid_now);
         if (accept) begin
            dut_in_q <= ZERO_FIRST ? '0 : seed_nz;
            idx_q    <= '0;
            drain_q  <= '0;
         end else if (advance) begin
            dut_in_q <= lfsr_q;
            idx_q    <= idx_q + 1'b1;
         end
         if (state == DRAIN) begin
            drain_q <= drain_q + 1'b1;
         end
      end
   end

   galois_reg #(.W(IN_W), .POLY(POLY)) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .clear    (1'b0),
      .load     (accept),
      .step     (advance),
      .load_val (lfsr_load),
      .inject   ('0),
      .q        (lfsr_q)
   );

   galois_reg #(.W(SIG_W), .POLY(SIG_POLY)) u_misr (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .load     (1'b0),
      .step     (capture),
      .load_val ('0),
      .inject   (folded),
      .q        (sig_q)
   );

   assign bus.dut_in    = dut_in_q;
   assign bus.busy      = (state == RUN) || (state == DRAIN);
   assign bus.done      = (state == DONE);
   assign bus.vec_idx   = idx_q;
   assign bus.signature = sig_q;

endmodule

// File: tb/tb_vec_sig_harness.sv
// Bench for vec_sig_harness: a small 8-bit loopback instance and a default
// width instance behind a two-stage register DUT, both checked against a
// queue-based model of the vector run and the signature it should produce.
module tb_vec_sig_harness;

   localparam int BIG_OUT = 474;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   logic [63:0]        exp_vec[$];
   logic [BIG_OUT-1:0] big_r1;
   logic [BIG_OUT-1:0] big_r2;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic [63:0] din;
      logic [63:0] idx;
      logic [63:0] sig;
   } obs_t;

   always #5 clk = ~clk;

   vec_sig_harness_if #(.IN_W(8), .OUT_W(8), .SIG_W(8), .NUM_VEC(4)) sbus ();
   vec_sig_harness_if #(.IN_W(64), .OUT_W(BIG_OUT), .SIG_W(32), .NUM_VEC(21)) bbus ();

   vec_sig_harness #(
      .IN_W(8), .OUT_W(8), .SIG_W(8), .NUM_VEC(4), .LAT(0),
      .POLY(8'hB8), .SIG_POLY(8'hB8), .ZERO_FIRST(1'b0)
   ) u_small (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   vec_sig_harness #(
      .IN_W(64), .OUT_W(BIG_OUT), .SIG_W(32), .NUM_VEC(21), .LAT(2),
      .POLY(64'hD800000000000000), .SIG_POLY(32'h82608EDB), .ZERO_FIRST(1'b1)
   ) u_big (
      .clk (clk),
      .rst (rst),
      .bus (bbus)
   );

   // Arbitrary but fixed wide response of the device behind the big harness.
   function automatic logic [BIG_OUT-1:0] big_response(input logic [63:0] v);
      logic [BIG_OUT-1:0] r;
      for (int i = 0; i < BIG_OUT; i++) begin
         r[i] = v[i % 64] ^ v[(i * 7 + 3) % 64] ^ ((i % 5) == 0);
      end
      return r;
   endfunction

   // Small DUT is a wire; big DUT is a two-register pipeline.
   assign sbus.dut_out = sbus.dut_in;
   always_ff @(posedge clk) begin
      big_r1 <= big_response(bbus.dut_in);
      big_r2 <= big_r1;
   end
   assign bbus.dut_out = big_r2;

   function automatic logic [63:0] lfsr_next(input logic [63:0] s, input logic [63:0] poly);
      return (s >> 1) ^ ((s % 2 == 1) ? poly : 64'd0);
   endfunction

   function automatic logic [31:0] big_fold(input logic [BIG_OUT-1:0] r);
      logic [BIG_OUT+31:0] padded;
      logic [31:0]         acc;
      padded = {32'd0, r};
      acc    = '0;
      for (int base = 0; base < BIG_OUT; base += 32) begin
         acc = acc ^ padded[base +: 32];
      end
      return acc;
   endfunction

   // Expected vector list for one run.
   task automatic build_vectors(input logic [63:0] seed, input logic [63:0] poly,
                                input int n, input bit zf);
      logic [63:0] s;
      s = (seed == 64'd0) ? 64'd1 : seed;
      exp_vec.delete();
      if (zf) exp_vec.push_back(64'd0);
      while (exp_vec.size() < n) begin
         exp_vec.push_back(s);
         s = lfsr_next(s, poly);
      end
   endtask

   // Signature after the first 'upto' responses have been captured.
   function automatic logic [63:0] expected_sig(input bit big, input int upto);
      logic [31:0] s32;
      logic [7:0]  s8;
      s32 = '0;
      s8  = '0;
      for (int k = 0; k < upto; k++) begin
         if (big) s32 = ((s32 >> 1) ^ (s32[0] ? 32'h82608EDB : 32'h0))
                        ^ big_fold(big_response(exp_vec[k]));
         else     s8  = ((s8 >> 1) ^ (s8[0] ? 8'hB8 : 8'h0)) ^ exp_vec[k][7:0];
      end
      return big ? {32'd0, s32} : {56'd0, s8};
   endfunction

   function automatic obs_t observe(input bit big);
      obs_t o;
      if (big) begin
         o.busy = bbus.busy;
         o.done = bbus.done;
         o.din  = bbus.dut_in;
         o.idx  = 64'(bbus.vec_idx);
         o.sig  = 64'(bbus.signature);
      end else begin
         o.busy = sbus.busy;
         o.done = sbus.done;
         o.din  = 64'(sbus.dut_in);
         o.idx  = 64'(sbus.vec_idx);
         o.sig  = 64'(sbus.signature);
      end
      return o;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input bit big, input logic start, input logic abort,
                                 input logic [63:0] seed);
      if (big) begin
         bbus.start = start;
         bbus.abort = abort;
         bbus.seed  = seed;
      end else begin
         sbus.start = start;
         sbus.abort = abort;
         sbus.seed  = seed[7:0];
      end
   endtask

   task automatic check_reset(input bit big);
      obs_t o;
      o = observe(big);
      check_output(big ? "big_rst_busy" : "sm_rst_busy", 64'(o.busy), 64'd0);
      check_output(big ? "big_rst_done" : "sm_rst_done", 64'(o.done), 64'd0);
      check_output(big ? "big_rst_din"  : "sm_rst_din",  o.din, 64'd0);
      check_output(big ? "big_rst_idx"  : "sm_rst_idx",  o.idx, 64'd0);
      check_output(big ? "big_rst_sig"  : "sm_rst_sig",  o.sig, 64'd0);
   endtask

   task automatic prepare(input bit big, input logic [63:0] seed);
      if (big) build_vectors(seed, 64'hD800000000000000, 21, 1'b1);
      else     build_vectors({56'd0, seed[7:0]}, 64'h00000000000000B8, 4, 1'b0);
   endtask

   // One complete run, optionally pulsing start mid-run to show it is ignored.
   task automatic run_check(input bit big, input logic [63:0] seed, input bit poke_start);
      int   n;
      int   lat;
      int   cyc;
      obs_t o;
      n   = big ? 21 : 4;
      lat = big ? 2 : 0;
      prepare(big, seed);
      apply_stimulus(big, 1'b1, 1'b0, seed);
      @(negedge clk);
      apply_stimulus(big, 1'b0, 1'b0, seed);
      cyc = 0;
      o   = observe(big);
      check_output("done_low_at_start", 64'(o.done), 64'd0);
      while (o.busy && cyc < 100) begin
         check_output("dut_in", o.din, exp_vec[cyc < n ? cyc : n - 1]);
         check_output("vec_idx", o.idx, 64'(cyc < n ? cyc : n - 1));
         apply_stimulus(big, poke_start && cyc == 1, 1'b0, ~seed);
         @(negedge clk);
         cyc++;
         o = observe(big);
      end
      apply_stimulus(big, 1'b0, 1'b0, seed);
      check_output("run_length", 64'(cyc), 64'(n + lat));
      check_output("done", 64'(o.done), 64'd1);
      check_output("signature", o.sig, expected_sig(big, n));
   endtask

   // Abort at vec_idx 2: two responses captured, none on the abort edge.
   task automatic abort_check(input logic [63:0] seed);
      obs_t o;
      prepare(1'b0, seed);
      apply_stimulus(1'b0, 1'b1, 1'b0, seed);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, seed);
      repeat (2) @(negedge clk);
      o = observe(1'b0);
      check_output("abort_idx", o.idx, 64'd2);
      apply_stimulus(1'b0, 1'b1, 1'b1, seed);
      @(negedge clk);
      apply_stimulus(1'b0, 1'b0, 1'b0, seed);
      o = observe(1'b0);
      check_output("abort_busy", 64'(o.busy), 64'd0);
      check_output("abort_done", 64'(o.done), 64'd0);
      check_output("abort_din", o.din, 64'd0);
      check_output("abort_sig", o.sig, expected_sig(1'b0, 2));
      @(negedge clk);
      o = observe(1'b0);
      check_output("abort_stays_idle", 64'(o.busy), 64'd0);
   endtask

   // Asynchronous reset in the first DRAIN cycle of the big harness.
   task automatic reset_in_drain(input logic [63:0] seed);
      obs_t o;
      prepare(1'b1, seed);
      apply_stimulus(1'b1, 1'b1, 1'b0, seed);
      @(negedge clk);
      apply_stimulus(1'b1, 1'b0, 1'b0, seed);
      repeat (21) @(negedge clk);
      o = observe(1'b1);
      check_output("drain_busy", 64'(o.busy), 64'd1);
      check_output("drain_hold", o.din, exp_vec[20]);
      #2 rst = 1'b1;
      #1 check_reset(1'b1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [63:0] s;
      rst = 1'b1;
      apply_stimulus(1'b0, 1'b0, 1'b0, 64'd0);
      apply_stimulus(1'b1, 1'b0, 1'b0, 64'd0);
      #3;
      check_reset(1'b0);
      check_reset(1'b1);
      @(negedge clk);
      rst = 1'b0;

      run_check(1'b0, 64'h01, 1'b1);
      check_output("plan_sig_seed1", 64'(sbus.signature), 64'h00);
      run_check(1'b0, 64'h00, 1'b0);
      check_output("plan_sig_seed0", 64'(sbus.signature), 64'h00);

      s = 64'($urandom_range(1, 255));
      abort_check(s);
      run_check(1'b0, s, 1'b0);
      for (int i = 0; i < 3; i++) begin
         run_check(1'b0, 64'($urandom), i == 0);
      end

      for (int i = 0; i < 2; i++) begin
         run_check(1'b1, {$urandom, $urandom}, i == 0);
      end
      s = {$urandom, $urandom};
      reset_in_drain(s);
      run_check(1'b1, s, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vec_sig_harness.md
# vec_sig_harness

Synthesizable, parametrised stimulus/signature harness for differential netlist-vs-RTL checks.
- Generates a run of pseudo-random input vectors for a device under test (DUT), one per clock.
- Compacts the DUT's wide output into a short multiple-input signature register (MISR) signature, so a synthesized netlist and its RTL can be compared by one word instead of per-cycle strobes.
- Sits between the top-level bench and the DUT; supports arbitrary input/output widths, run length, pipeline latency and an optional all-zero first vector.

## Interface
- IN_W, 64 — concatenated DUT input width.
- OUT_W, 474 — DUT output width.
- SIG_W, 32 — signature width.
- NUM_VEC, 21 — vectors per run (≥1).
- LAT, 0 — DUT latency in cycles from dut_in to dut_out (0 = combinational).
- POLY, {IN_W{1'b0}} | 64'hD800000000000000 — Galois feedback for the vector LFSR.
- SIG_POLY, 32'h82608EDB — Galois feedback for the MISR.
- ZERO_FIRST, 1 — when 1, vector 0 is all-zero and LFSR output starts at vector 1.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- abort  in  1  terminate current run; no signature produced.
- seed  in  IN_W  LFSR seed latched on accepted start; 0 is replaced by 1.
- dut_in  out  IN_W  registered vector driven to DUT.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE until next start/abort.
- vec_idx  out  $clog2(NUM_VEC+1)  index of vector currently on dut_in.
- signature  out  SIG_W  MISR state; final when done=1.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start → RUN. On the same edge: lfsr←seed (or 1), sig←0, vec_idx←0, dut_in←vector 0.
- RUN: each edge advances vec_idx and dut_in to the next vector.
  - After vector NUM_VEC-1 has been held one cycle → DRAIN if LAT>0, else DONE.
- DRAIN: holds dut_in at the last vector for LAT cycles → DONE.
- DONE: done=1, signature frozen.
- abort (any state) → IDLE on next edge. dut_in←0, done=0, signature left as is, no sig update that edge. abort beats start.
- LFSR step (Galois, right shift): s' = (s>>1) ^ (s[0] ? POLY : 0).
- Vector k = LFSR state after k steps from seed; with ZERO_FIRST, vector 0 = 0 and vector k = state after k-1 steps.
- Capture: a valid bit travels with each applied vector through an LAT-deep shift register.
  - On an edge where the delayed valid is set: sig' = step_SIG_POLY(sig) ^ fold(dut_out).
- fold: XOR of all SIG_W-bit slices of dut_out, LSB-aligned, last slice zero-padded.
- Exactly NUM_VEC captures per completed run.

## Timing
- Reset values: dut_in=0, busy=0, done=0, vec_idx=0, signature=0, state IDLE, valid pipe cleared.
- Start-to-done = NUM_VEC + LAT cycles; done rises on the edge after the last capture edge.
- Vector k appears after the start edge plus k edges; its response is sampled at the edge ending cycle k+LAT.
- start while busy: ignored.
- start in DONE: restarts immediately, done falls the same edge.
- Reset mid-run: immediate return to reset values; no partial done.

## Structure
- Package harness_pkg holds:
  - state enum;
  - function galois_step(s, poly);
  - function fold(data) parametrised by SIG_W via a typed wrapper or width arguments.
- Sub-module galois_reg (width W, poly, inject input, load/clear) is instantiated twice:
  - as the vector LFSR (inject=0);
  - as the MISR (inject=fold(dut_out)).
- The FSM and the valid pipe live in the top.

## Test plan
- IN_W=OUT_W=SIG_W=8, POLY=SIG_POLY=8'hB8, NUM_VEC=4, LAT=0, ZERO_FIRST=0, seed=8'h01, DUT = wire loopback → dut_in sequence 01,B8,5C,2E; signature=8'h00; done 4 cycles after start.
- Same, seed=0 → identical to seed 1.
- Same, ZERO_FIRST=1 → dut_in 00,01,B8,5C; captures 4.
- Same, LAT=2 with a 2-stage register DUT → signature equals the LAT=0 result; done 6 cycles after start; dut_in held at 2E during DRAIN.
- abort asserted at vec_idx=2 → IDLE next edge, busy=0, done=0. Subsequent start gives the clean-run signature.
- rst pulsed mid-DRAIN, OUT_W=474 default DUT → all outputs at reset values asynchronously. Rerun matches the RTL-vs-netlist golden signature.
